// File: rtl/cache_pkg.sv
// Shared definitions for the cache tag controller: state encoding, address
// field widths and tag-entry bit positions.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WB_REQ    = 3'd2,
    ST_WB_WAIT   = 3'd3,
    ST_FILL_REQ  = 3'd4,
    ST_FILL_WAIT = 3'd5,
    ST_UPDATE    = 3'd6
  } state_e;

  localparam int BYTE_OFFSET_BITWIDTH = 2;
  localparam int MISS_COUNT_BITWIDTH  = 16;
  localparam logic [MISS_COUNT_BITWIDTH-1:0] MISS_COUNT_MAX = 16'hFFFF;

  function automatic int tag_bitwidth(input int addr_w, input int line_w, input int col_w);
    return addr_w - line_w - col_w - BYTE_OFFSET_BITWIDTH;
  endfunction

  function automatic int line_lsb(input int col_w);
    return BYTE_OFFSET_BITWIDTH + col_w;
  endfunction

  function automatic int tag_lsb(input int col_w, input int line_w);
    return BYTE_OFFSET_BITWIDTH + col_w + line_w;
  endfunction

  // Entry layout: {valid, dirty, tag}
  function automatic int entry_valid_pos(input int tag_w);
    return tag_w + 1;
  endfunction

  function automatic int entry_dirty_pos(input int tag_w);
    return tag_w;
  endfunction

endpackage

// File: rtl/cache_tag_ctrl.sv
// Direct-mapped cache tag controller: tag-RAM init sweep, zero-latency hit
// detection, and writeback/fill sequencing toward the memory side.
module cache_tag_ctrl
  import cache_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH   = 32,
  parameter int LINE_IX_BITWIDTH   = 8,
  parameter int COLUMN_IX_BITWIDTH = 3,
  localparam int TAG_BITWIDTH = tag_bitwidth(ADDRESS_BITWIDTH, LINE_IX_BITWIDTH, COLUMN_IX_BITWIDTH)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     cpu_valid,
  input  logic                                     cpu_write,
  input  logic [ADDRESS_BITWIDTH-1:0]              cpu_address,
  output logic                                     cpu_ready,
  output logic [LINE_IX_BITWIDTH-1:0]              tag_address,
  input  logic [TAG_BITWIDTH+1:0]                  tag_data_in,
  output logic [TAG_BITWIDTH+1:0]                  tag_data_out,
  output logic                                     tag_write_enable,
  output logic                                     mem_cmd_valid,
  output logic                                     mem_cmd_write,
  output logic [TAG_BITWIDTH+LINE_IX_BITWIDTH-1:0] mem_cmd_line_address,
  input  logic                                     mem_cmd_ready,
  input  logic                                     mem_done,
  output logic                                     busy,
  output logic [MISS_COUNT_BITWIDTH-1:0]           miss_count
);

  localparam int VALID_POS = entry_valid_pos(TAG_BITWIDTH);
  localparam int DIRTY_POS = entry_dirty_pos(TAG_BITWIDTH);
  localparam int LINE_LSB  = line_lsb(COLUMN_IX_BITWIDTH);
  localparam int TAG_LSB   = tag_lsb(COLUMN_IX_BITWIDTH, LINE_IX_BITWIDTH);
  localparam logic [LINE_IX_BITWIDTH-1:0] LAST_LINE = '1;
  localparam logic [LINE_IX_BITWIDTH-1:0] LINE_ONE  = {{(LINE_IX_BITWIDTH-1){1'b0}}, 1'b1};
  localparam logic [MISS_COUNT_BITWIDTH-1:0] MISS_ONE = 16'd1;

  state_e                          state_r;
  state_e                          state_s;
  logic [LINE_IX_BITWIDTH-1:0]     init_line_r;
  logic [LINE_IX_BITWIDTH-1:0]     req_line_r;
  logic [TAG_BITWIDTH-1:0]         req_tag_r;
  logic [TAG_BITWIDTH-1:0]         victim_tag_r;
  logic [MISS_COUNT_BITWIDTH-1:0]  miss_count_r;

  logic [LINE_IX_BITWIDTH-1:0]     req_line_s;
  logic [TAG_BITWIDTH-1:0]         req_tag_s;
  logic [TAG_BITWIDTH-1:0]         entry_tag_s;
  logic                            entry_valid_s;
  logic                            entry_dirty_s;
  logic                            hit_s;
  logic                            miss_s;
  logic                            unused_addr_bits_s;

  assign req_line_s         = cpu_address[LINE_LSB +: LINE_IX_BITWIDTH];
  assign req_tag_s          = cpu_address[TAG_LSB +: TAG_BITWIDTH];
  assign entry_tag_s        = tag_data_in[TAG_BITWIDTH-1:0];
  assign entry_valid_s      = tag_data_in[VALID_POS];
  assign entry_dirty_s      = tag_data_in[DIRTY_POS];
  assign hit_s              = entry_valid_s && (entry_tag_s == req_tag_s);
  assign unused_addr_bits_s = ^cpu_address[LINE_LSB-1:0];
  assign miss_count         = miss_count_r;

  // Next-state and output decode; hits complete combinationally in IDLE
  always_comb begin
    state_s              = state_r;
    cpu_ready            = 1'b0;
    busy                 = (state_r != ST_IDLE);
    tag_address          = req_line_r;
    tag_data_out         = '0;
    tag_write_enable     = 1'b0;
    mem_cmd_valid        = 1'b0;
    mem_cmd_write        = 1'b0;
    mem_cmd_line_address = '0;
    miss_s               = 1'b0;
    case (state_r)
      ST_INIT: begin
        tag_address      = init_line_r;
        // reset is asynchronous, so the sweep write must not leak while it is held
        tag_write_enable = rst_n;
        if (init_line_r == LAST_LINE) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        tag_address = req_line_s;
        if (cpu_valid) begin
          if (hit_s) begin
            cpu_ready = 1'b1;
            if (cpu_write && !entry_dirty_s) begin
              tag_write_enable = 1'b1;
              tag_data_out     = {1'b1, 1'b1, req_tag_s};
            end else begin
              tag_write_enable = 1'b0;
            end
          end else begin
            miss_s = 1'b1;
            if (entry_valid_s && entry_dirty_s) begin
              state_s = ST_WB_REQ;
            end else begin
              state_s = ST_FILL_REQ;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WB_REQ: begin
        mem_cmd_valid        = 1'b1;
        mem_cmd_write        = 1'b1;
        mem_cmd_line_address = {victim_tag_r, req_line_r};
        if (mem_cmd_ready) begin
          state_s = ST_WB_WAIT;
        end else begin
          state_s = ST_WB_REQ;
        end
      end
      ST_WB_WAIT: begin
        if (mem_done) begin
          state_s = ST_FILL_REQ;
        end else begin
          state_s = ST_WB_WAIT;
        end
      end
      ST_FILL_REQ: begin
        mem_cmd_valid        = 1'b1;
        mem_cmd_line_address = {req_tag_r, req_line_r};
        if (mem_cmd_ready) begin
          state_s = ST_FILL_WAIT;
        end else begin
          state_s = ST_FILL_REQ;
        end
      end
      ST_FILL_WAIT: begin
        if (mem_done) begin
          state_s = ST_UPDATE;
        end else begin
          state_s = ST_FILL_WAIT;
        end
      end
      ST_UPDATE: begin
        tag_write_enable = 1'b1;
        tag_data_out     = {1'b1, 1'b0, req_tag_r};
        state_s          = ST_IDLE;
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Init sweep line counter; wraps back to zero as the sweep finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_line_r <= '0;
    end else if (state_r == ST_INIT) begin
      init_line_r <= init_line_r + LINE_ONE;
    end else begin
      init_line_r <= init_line_r;
    end
  end

  // Capture request and victim on a miss so the sequence survives cpu_valid dropping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_line_r   <= '0;
      req_tag_r    <= '0;
      victim_tag_r <= '0;
    end else if (miss_s) begin
      req_line_r   <= req_line_s;
      req_tag_r    <= req_tag_s;
      victim_tag_r <= entry_tag_s;
    end else begin
      req_line_r   <= req_line_r;
      req_tag_r    <= req_tag_r;
      victim_tag_r <= victim_tag_r;
    end
  end

  // Saturating miss counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count_r <= '0;
    end else if (miss_s && (miss_count_r != MISS_COUNT_MAX)) begin
      miss_count_r <= miss_count_r + MISS_ONE;
    end else begin
      miss_count_r <= miss_count_r;
    end
  end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Randomized bench for cache_tag_ctrl: a line-level cache model predicts the
// ordered stream of tag writes, memory commands and completions.
module tb_cache_tag_ctrl;

  typedef struct packed {
    logic [1:0]  kind;   // 0 tag write, 1 mem command, 2 cpu ready
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid, cpu_write, cpu_ready;
  logic [31:0] cpu_address;
  logic [7:0]  tag_address;
  logic [20:0] tag_data_in, tag_data_out;
  logic        tag_write_enable, mem_cmd_valid, mem_cmd_write;
  logic [26:0] mem_cmd_line_address;
  logic        mem_cmd_ready, mem_done, busy;
  logic [15:0] miss_count;

  cache_tag_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_address(cpu_address), .cpu_ready(cpu_ready),
    .tag_address(tag_address), .tag_data_in(tag_data_in), .tag_data_out(tag_data_out),
    .tag_write_enable(tag_write_enable),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_line_address(mem_cmd_line_address), .mem_cmd_ready(mem_cmd_ready), .mem_done(mem_done),
    .busy(busy), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // tag RAM beside the controller
  logic [20:0] tag_ram [256];
  assign tag_data_in = tag_ram[tag_address];
  always @(posedge clk) if (tag_write_enable) tag_ram[tag_address] <= tag_data_out;

  int  n_chk = 0;
  int  n_fail = 0;
  ev_t exp_q[$];

  logic        mv [256];
  logic        md [256];
  logic [18:0] mt [256];
  logic [15:0] mmiss;

  logic [20:0] last_tw_data;
  logic [26:0] last_wb_addr, last_fill_addr;
  int          fill_seen = 0;
  int          ready_mode = 0;
  bit          hold_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    return e;
  endfunction

  task automatic observe(input ev_t got);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d a=0x%0h d=0x%0h, none expected", got.kind, got.a, got.d);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL event_order: got kind=%0d a=0x%0h d=0x%0h expected kind=%0d a=0x%0h d=0x%0h",
                 got.kind, got.a, got.d, e.kind, e.a, e.d);
      end
    end
  endtask

  // After reset every line becomes invalid, written in ascending order
  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 19'd0;
      exp_q.push_back(mk(2'd0, i, 32'd0));
    end
    mmiss = 16'd0;
  endtask

  task automatic model_expect(input logic [31:0] addr, input logic wr);
    logic [7:0]  line;
    logic [18:0] tag;
    line = addr[12:5];
    tag  = addr[31:13];
    if (!(mv[line] && mt[line] == tag)) begin
      if (mmiss != 16'hFFFF) mmiss = mmiss + 16'd1;
      if (mv[line] && md[line]) exp_q.push_back(mk(2'd1, {5'd0, mt[line], line}, 32'd1));
      exp_q.push_back(mk(2'd1, {5'd0, tag, line}, 32'd0));
      exp_q.push_back(mk(2'd0, {24'd0, line}, {11'd0, 2'b10, tag}));
      mv[line] = 1'b1; md[line] = 1'b0; mt[line] = tag;
    end
    if (wr && !md[line]) begin
      exp_q.push_back(mk(2'd0, {24'd0, line}, {11'd0, 2'b11, tag}));
      md[line] = 1'b1;
    end
    exp_q.push_back(mk(2'd2, 32'd0, {16'd0, mmiss}));
  endtask

  // Compare process: checks every observable event and per-cycle rules
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cmd_twe_exclusive", {31'd0, mem_cmd_valid && tag_write_enable}, 32'd0);
      if (cpu_valid && !busy) chk("idle_tag_address", {24'd0, tag_address}, {24'd0, cpu_address[12:5]});
      if (tag_write_enable) begin
        last_tw_data = tag_data_out;
        observe(mk(2'd0, {24'd0, tag_address}, {11'd0, tag_data_out}));
      end
      if (mem_cmd_valid && mem_cmd_ready) begin
        if (mem_cmd_write) last_wb_addr = mem_cmd_line_address;
        else begin
          last_fill_addr = mem_cmd_line_address;
          fill_seen++;
        end
        observe(mk(2'd1, {5'd0, mem_cmd_line_address}, {31'd0, mem_cmd_write}));
      end
      if (cpu_ready) observe(mk(2'd2, 32'd0, {16'd0, miss_count}));
    end
  end

  // Memory responder: random ready, random burst latency, spurious done pulses while idle
  initial begin
    bit acc;
    int cnt;
    bit pending;
    pending = 1'b0; cnt = 0;
    mem_cmd_ready = 1'b0;
    mem_done = 1'b0;
    forever begin
      @(negedge clk);
      acc = (rst_n === 1'b1) && mem_cmd_valid && mem_cmd_ready;
      @(posedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        pending = 1'b0; mem_done = 1'b0; mem_cmd_ready = 1'b0;
      end else begin
        if (pending) begin
          mem_done = 1'b0;
          if (!hold_done) begin
            if (cnt == 0) begin mem_done = 1'b1; pending = 1'b0; end
            else cnt--;
          end
        end else if (acc) begin
          mem_done = 1'b0;
          pending = 1'b1;
          cnt = $urandom_range(0, 5);
        end else if (ready_mode == 2) mem_done = !mem_done;
        else mem_done = ($urandom_range(0, 9) == 0);
        case (ready_mode)
          0:       mem_cmd_ready = 1'b1;
          1:       mem_cmd_ready = ($urandom_range(0, 2) != 0);
          default: mem_cmd_ready = 1'b0;
        endcase
      end
    end
  end

  task automatic do_access(input logic [31:0] addr, input logic wr);
    bit done;
    model_expect(addr, wr);
    cpu_valid = 1'b1; cpu_write = wr; cpu_address = addr;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (cpu_ready) done = 1'b1;
    end
    if (!done) chk("access_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
  endtask

  task automatic wait_init();
    int cnt;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    chk("init_busy_cycles", cnt, 32'd256);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [18:0] tag;
    logic [7:0]  line;
    tag  = 19'($urandom_range(0, 3));
    line = 8'($urandom_range(0, 3));
    return {tag, line, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    logic [26:0] cap;
    bit seen;
    int f0;
    rst_n = 1'b0; cpu_valid = 1'b0; cpu_write = 1'b0; cpu_address = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_twe", {31'd0, tag_write_enable}, 32'd0);
    chk("rst_cmd_valid", {31'd0, mem_cmd_valid}, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init();

    // cold read, line 2 tag 1; valid is bit 20 with the 19-bit tag
    do_access(32'h0000_2040, 1'b0);
    chk("cold_fill_addr", {5'd0, last_fill_addr}, 32'h102);
    chk("cold_update_data", {11'd0, last_tw_data}, 32'h100001);
    chk("cold_miss_count", {16'd0, miss_count}, 32'd1);
    do_access(32'h0000_2040, 1'b1);
    chk("store_hit_data", {11'd0, last_tw_data}, 32'h180001);
    chk("store_hit_miss_count", {16'd0, miss_count}, 32'd1);
    do_access(32'h0000_4040, 1'b0);
    chk("evict_wb_addr", {5'd0, last_wb_addr}, 32'h102);
    chk("evict_fill_addr", {5'd0, last_fill_addr}, 32'h202);
    chk("evict_update_data", {11'd0, last_tw_data}, 32'h100002);
    chk("evict_miss_count", {16'd0, miss_count}, 32'd2);

    // memory stalls with done pulses arriving while the fill command waits
    ready_mode = 2;
    @(posedge clk);
    #1;
    fork
      do_access(32'h0000_6040, 1'b0);
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (mem_cmd_valid) seen = 1'b1;
        end
        chk("stall_cmd_seen", {31'd0, seen}, 32'd1);
        cap = mem_cmd_line_address;
        chk("stall_cmd_addr", {5'd0, cap}, 32'h302);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("stall_valid_held", {31'd0, mem_cmd_valid}, 32'd1);
          chk("stall_addr_held", {5'd0, mem_cmd_line_address}, {5'd0, cap});
          chk("stall_no_update", {31'd0, tag_write_enable}, 32'd0);
        end
        ready_mode = 0;
      end
    join

    ready_mode = 1;
    for (int n = 0; n < 250; n++) begin
      do_access(rand_addr(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    // reset while a fill burst is outstanding
    ready_mode = 0;
    hold_done = 1'b1;
    model_expect(32'h0000_E0A0, 1'b0);
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_address = 32'h0000_E0A0;
    f0 = fill_seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (fill_seen != f0) seen = 1'b1;
    end
    chk("rst_fill_seen", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd_valid", {31'd0, mem_cmd_valid}, 32'd0);
    chk("midrst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("midrst_twe", {31'd0, tag_write_enable}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    chk("midrst_miss_count", {16'd0, miss_count}, 32'd0);
    cpu_valid = 1'b0;
    exp_q.delete();
    hold_done = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
    wait_init();
    chk("post_rst_miss_count", {16'd0, miss_count}, 32'd0);

    ready_mode = 1;
    for (int n = 0; n < 40; n++) do_access(rand_addr(), 1'($urandom_range(0, 1)));
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
